// File: rtl/scs8hd_clkdiv_n_pkg.sv
// scs8hd_clkdiv_n shared definitions.
// State encoding and default widths.
package scs8hd_clkdiv_n_pkg;

  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] ST_PARK   = 2'b00;
  localparam logic [1:0] ST_RUN_LO = 2'b01;
  localparam logic [1:0] ST_RUN_HI = 2'b11;

endpackage

// File: rtl/scs8hd_clkdiv_cnt.sv
// Half-period counter for scs8hd_clkdiv_n.
// Terminal compare plus full-period boundary strobe.
module scs8hd_clkdiv_cnt
  import scs8hd_clkdiv_n_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             en,
  input  logic             clr,
  input  logic             hi,
  input  logic [CNT_W-1:0] lim,
  output logic             term,
  output logic             bnd
);

  logic [CNT_W-1:0] cnt;

  assign term = en && (cnt == lim);
  assign bnd  = term && hi;

  // count up while running, restart at terminal or on park
  always_ff @(posedge clk) begin
    if (!resetb || !en || clr || term)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/scs8hd_clkdiv_n.sv
// Programmable 50%-duty clock divider/inverter cell.
// Ratio changes land only on full-period boundaries.
module scs8hd_clkdiv_n
  import scs8hd_clkdiv_n_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = 0
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             EN,
  input  logic             INV,
  input  logic [CNT_W-1:0] DIV,
  input  logic             DIV_VLD,
  output logic             DIV_RDY,
  output logic             Y,
  output logic             TICK,
  output logic             RUN
`ifdef SC_USE_PG_PIN
  ,
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb
`endif
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);

  logic [1:0]       st;
  logic [1:0]       st_nxt;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] div_p;
  logic             pend;
  logic             inv_r;
  logic             inv_nxt;
  logic             y_r;
  logic             tick_r;
  logic             term;
  logic             bnd;
  logic             park_nxt;
  logic             cap_inv;

  scs8hd_clkdiv_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (CLK),
    .resetb(RESETB),
    .en    (RUN),
    .clr   (park_nxt),
    .hi    (st == ST_RUN_HI),
    .lim   (div_r),
    .term  (term),
    .bnd   (bnd)
  );

  assign RUN      = (st != ST_PARK);
  assign DIV_RDY  = ~pend;
  assign park_nxt = (st_nxt == ST_PARK);
  assign cap_inv  = (st == ST_PARK) && !EN;
  assign inv_nxt  = cap_inv ? INV : inv_r;

  // next phase: a high phase always runs to its boundary
  always_comb begin
    st_nxt = st;
    unique case (1'b1)
      (st == ST_PARK):
        if (EN) st_nxt = ST_RUN_LO;
      (st == ST_RUN_LO):
        if (!EN) st_nxt = ST_PARK;
        else if (term) st_nxt = ST_RUN_HI;
      (st == ST_RUN_HI):
        if (term) st_nxt = EN ? ST_RUN_LO : ST_PARK;
      default:
        st_nxt = ST_PARK;
    endcase
  end

  // phase, polarity, ratio handshake and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      st     <= ST_PARK;
      inv_r  <= 1'b0;
      div_r  <= DIV_INIT;
      div_p  <= DIV_INIT;
      pend   <= 1'b0;
      y_r    <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      st    <= st_nxt;
      inv_r <= inv_nxt;
      if (DIV_VLD && !pend) begin
        div_p <= DIV;
        pend  <= 1'b1;
      end else if (pend && (!RUN || bnd)) begin
        div_r <= div_p;
        pend  <= 1'b0;
      end
      y_r    <= (st_nxt == ST_RUN_HI) ^ inv_nxt;
      tick_r <= (st_nxt == ST_RUN_HI) && (st == ST_RUN_LO);
    end
  end

`ifdef SC_USE_PG_PIN
  logic pg_unused;
  assign pg_unused = ^{vpb, vnb};
  scs8hd_pg_U_VPWR_VGND u_pg_y (Y, y_r, vpwr, vgnd);
  scs8hd_pg_U_VPWR_VGND u_pg_t (TICK, tick_r, vpwr, vgnd);
`else
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
  logic pg_unused;
  assign pg_unused = ^{vpwr, vgnd, vpb, vnb};
  assign Y    = y_r;
  assign TICK = tick_r;
`endif

endmodule

// File: tb/tb_scs8hd_clkdiv_n.sv
// Directed-vector bench for scs8hd_clkdiv_n.
// Table of per-edge vectors plus long-period sequences.
module tb_scs8hd_clkdiv_n;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       inv;
    logic       vld;
    logic [3:0] div;
    logic       y;
    logic       tick;
    logic       rdy;
    logic       run;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       en = 1'b0;
  logic       inv = 1'b0;
  logic [3:0] div = 4'd0;
  logic       div_vld = 1'b0;
  logic       div_rdy;
  logic       y;
  logic       tick;
  logic       run;

  int errs = 0;
  int checks = 0;
  int stepn = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  scs8hd_clkdiv_n #(
    .CNT_W  (4),
    .DIV_RST(0)
  ) dut (
    .CLK    (clk),
    .RESETB (resetb),
    .EN     (en),
    .INV    (inv),
    .DIV    (div),
    .DIV_VLD(div_vld),
    .DIV_RDY(div_rdy),
    .Y      (y),
    .TICK   (tick),
    .RUN    (run)
  );

  function automatic vec_t v(
    input logic r, input logic e, input logic i,
    input logic vl, input logic [3:0] d,
    input logic ey, input logic et,
    input logic er, input logic eu);
    vec_t t;
    t.rst_n = r; t.en = e; t.inv = i;
    t.vld = vl; t.div = d;
    t.y = ey; t.tick = et;
    t.rdy = er; t.run = eu;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s step %0d: got %b want %b",
               nm, stepn, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    resetb  = t.rst_n;
    en      = t.en;
    inv     = t.inv;
    div_vld = t.vld;
    div     = t.div;
    @(posedge clk);
    #1;
    stepn++;
    chk("Y", y, t.y);
    chk("TICK", tick, t.tick);
    chk("DIV_RDY", div_rdy, t.rdy);
    chk("RUN", run, t.run);
  endtask

  initial begin
    // reset, then CLK/2
    tv.push_back(v(0,0,0,0,0, 0,0,1,0));
    tv.push_back(v(0,0,0,0,0, 0,0,1,0));
    tv.push_back(v(1,0,0,0,0, 0,0,1,0));
    tv.push_back(v(1,1,0,0,0, 0,0,1,1));
    tv.push_back(v(1,1,0,0,0, 1,1,1,1));
    tv.push_back(v(1,1,0,0,0, 0,0,1,1));
    tv.push_back(v(1,1,0,0,0, 1,1,1,1));
    tv.push_back(v(1,1,0,0,0, 0,0,1,1));
    // ratio 3 transfer, applied at boundary
    tv.push_back(v(1,1,0,1,3, 1,1,0,1));
    tv.push_back(v(1,1,0,0,0, 0,0,1,1));
    for (int i = 0; i < 3; i++)
      tv.push_back(v(1,1,0,0,0, 0,0,1,1));
    tv.push_back(v(1,1,0,0,0, 1,1,1,1));
    for (int i = 0; i < 3; i++)
      tv.push_back(v(1,1,0,0,0, 1,0,1,1));
    for (int i = 0; i < 4; i++)
      tv.push_back(v(1,1,0,0,0, 0,0,1,1));
    tv.push_back(v(1,1,0,0,0, 1,1,1,1));
    // EN dropped inside high phase
    for (int i = 0; i < 3; i++)
      tv.push_back(v(1,0,0,0,0, 1,0,1,1));
    tv.push_back(v(1,0,0,0,0, 0,0,1,0));
    // parked polarity capture, then run
    tv.push_back(v(1,0,1,0,0, 1,0,1,0));
    tv.push_back(v(1,1,0,0,0, 1,0,1,1));
    for (int i = 0; i < 3; i++)
      tv.push_back(v(1,1,0,0,0, 1,0,1,1));
    tv.push_back(v(1,1,0,1,7, 0,1,0,1));
    tv.push_back(v(1,1,0,0,0, 0,0,0,1));
    // reset with ratio pending
    tv.push_back(v(0,1,0,0,0, 0,0,1,0));
    tv.push_back(v(1,0,0,0,0, 0,0,1,0));
    tv.push_back(v(1,1,0,0,0, 0,0,1,1));
    tv.push_back(v(1,1,0,0,0, 1,1,1,1));
    tv.push_back(v(1,1,0,0,0, 0,0,1,1));
    tv.push_back(v(1,1,0,0,0, 1,1,1,1));
    // transfer on boundary edge; ignored vld while busy
    tv.push_back(v(1,1,0,1,15, 0,0,0,1));
    tv.push_back(v(1,1,0,1,5, 1,1,0,1));
    tv.push_back(v(1,1,0,0,0, 0,0,1,1));

    #2;
    foreach (tv[k]) step(tv[k]);

    // full 32-cycle period at maximum ratio
    for (int i = 0; i < 15; i++)
      step(v(1,1,0,0,0, 0,0,1,1));
    step(v(1,1,0,0,0, 1,1,1,1));
    for (int i = 0; i < 15; i++)
      step(v(1,1,0,0,0, 1,0,1,1));
    step(v(1,1,0,0,0, 0,0,1,1));

    // EN low in low phase parks at once
    step(v(1,0,0,0,0, 0,0,1,0));
    step(v(1,0,0,0,0, 0,0,1,0));

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
